// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared widths, NOP encoding and state encodings for the fetch front end
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_FULL} slot_state_t;
  typedef enum logic {FETCH, DRAIN} fetch_state_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: redirect, instruction-memory and decode handshakes of the fetch unit
interface if_prefetch_unit_if;
  import rv_fetch_pkg::*;
  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;
  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemGnt;
  logic            ImemRvalid;
  logic [XLEN-1:0] ImemRdata;
  logic            InstrValid;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] InstrPC;
  logic            InstrReady;
  modport master (
    input  Redirect, RedirectPC, ImemGnt, ImemRvalid, ImemRdata, InstrReady,
    output ImemReq, ImemAddr, InstrValid, Instr, InstrPC
  );
  modport slave (
    output Redirect, RedirectPC, ImemGnt, ImemRvalid, ImemRdata, InstrReady,
    input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC
  );
endinterface

// File: rtl/ifq_slot_queue.sv
// ifq_slot_queue: in-order slot ring (reserve at tail, fill oldest pending, pop at head, flush)
module ifq_slot_queue
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            reserve,
  input  logic [XLEN-1:0] reserve_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_full,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data,
  output logic [CW-1:0]   occ_cnt,
  output logic [CW-1:0]   pend_cnt
);
  slot_state_t     st     [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   head, tail, fptr;
  // Responses are in order, so the oldest pending slot is always head + number of full slots.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      fptr <= '0;
      st   <= '{default: SLOT_EMPTY};
    end else begin
      if (reserve) begin
        st[tail] <= SLOT_PENDING;
        tail     <= tail + PW'(1);
      end
      if (fill) begin
        st[fptr] <= SLOT_FULL;
        fptr     <= fptr + PW'(1);
      end
      if (pop) begin
        st[head] <= SLOT_EMPTY;
        head     <= head + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reserve) pc_q[tail] <= reserve_pc;
    if (fill) data_q[fptr] <= fill_data;
  end
  always_comb begin
    occ_cnt  = '0;
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt  = occ_cnt + CW'(st[i] != SLOT_EMPTY);
      pend_cnt = pend_cnt + CW'(st[i] == SLOT_PENDING);
    end
  end
  assign head_full = st[head] == SLOT_FULL;
  assign head_pc   = pc_q[head];
  assign head_data = data_q[head];
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: RV32I fetch front end (fetch PC, imem requests, prefetch queue, redirect drain).
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to decode when the queue holds no full slot.
module if_prefetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  reset,
  if_prefetch_unit_if.master   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t    state, state_nxt;
  logic [CW-1:0]   drop_cnt, drop_nxt, occ_cnt, pend_cnt;
  logic [XLEN-1:0] fetch_pc, head_pc, head_data;
  logic            head_full, grant, fill, discard, pop, bypass;
  // Responses still owed to flushed requests count against the queue so slots never overcommit.
  assign bus.ImemReq  = !reset && !bus.Redirect && ((occ_cnt + drop_cnt) < CW'(DEPTH));
  assign bus.ImemAddr = fetch_pc;
  assign grant        = bus.ImemReq && bus.ImemGnt;
  assign fill         = bus.ImemRvalid && state == FETCH && !bus.Redirect;
  assign discard      = bus.ImemRvalid && state == DRAIN;
`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = fill && !head_full;
`else
  assign bypass = 1'b0;
`endif
  assign bus.InstrValid = head_full || bypass;
  assign bus.Instr      = head_full ? head_data : bypass ? bus.ImemRdata : RV_NOP;
  assign bus.InstrPC    = bus.InstrValid ? head_pc : '0;
  assign pop            = bus.InstrValid && bus.InstrReady && !bus.Redirect;
  ifq_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.Redirect),
    .reserve    (grant),
    .reserve_pc (fetch_pc),
    .fill       (fill),
    .fill_data  (bus.ImemRdata),
    .pop        (pop),
    .head_full  (head_full),
    .head_pc    (head_pc),
    .head_data  (head_data),
    .occ_cnt    (occ_cnt),
    .pend_cnt   (pend_cnt)
  );
  always_comb begin
    drop_nxt  = bus.Redirect ? drop_cnt + pend_cnt - CW'(bus.ImemRvalid)
              : discard      ? drop_cnt - CW'(1)
              : drop_cnt;
    state_nxt = (bus.Redirect || discard) ? ((drop_nxt != '0) ? DRAIN : FETCH) : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      fetch_pc <= bus.Redirect ? word_align(bus.RedirectPC) : grant ? fetch_pc + XLEN'(4) : fetch_pc;
    end
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: vector table, corner sequences and random traffic against a PC-stream model
module tb_if_prefetch_unit;
  import rv_fetch_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  if_prefetch_unit_if bus ();
  if_prefetch_unit_if wbus ();
  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (.clk(clk), .reset(reset), .bus(wbus));

  typedef struct {
    logic g, rv, rdy, rd;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[$];

  int checks = 0, failures = 0, cyc = 0;
  int gnt_pct, rdy_pct, redir_pct, max_dly;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  logic [31:0] exp_pc, exp_req, hold_pc, hold_instr;
  bit hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic g, rv, rdy, rd, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
    vec_t v;
    v.g = g; v.rv = rv; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic g, rv, rdy, rd, input logic [31:0] rpc);
    @(negedge clk);
    bus.ImemGnt    = g;
    bus.ImemRvalid = rv;
    bus.ImemRdata  = (rv && mq_addr.size() > 0) ? mem_word(mq_addr[0]) : 32'hDEAD_BEEF;
    bus.InstrReady = rdy;
    bus.Redirect   = rd;
    bus.RedirectPC = rpc;
    #1;
  endtask

  // Model: delivered PCs form a gapless +4 stream from the last reset/redirect target.
  task automatic commit();
    if (hold) begin
      chk("hold_valid", 32'(bus.InstrValid), 32'd1);
      chk("hold_pc", bus.InstrPC, hold_pc);
      chk("hold_instr", bus.Instr, hold_instr);
    end
    if (!bus.InstrValid) begin
      chk("idle_instr", bus.Instr, RV_NOP);
      chk("idle_pc", bus.InstrPC, 32'd0);
    end else if (bus.InstrReady && !bus.Redirect) begin
      chk("deliver_pc", bus.InstrPC, exp_pc);
      chk("deliver_instr", bus.Instr, mem_word(exp_pc));
      exp_pc += 32'd4;
    end
    if (bus.ImemReq) chk("req_addr", bus.ImemAddr, exp_req);
    if (bus.ImemReq && bus.ImemGnt) begin
      mq_addr.push_back(bus.ImemAddr);
      mq_due.push_back(cyc + 1 + int'($urandom_range(0, max_dly)));
      exp_req += 32'd4;
    end
    if (bus.ImemRvalid && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    chk("outstanding_le_depth", 32'(mq_addr.size() <= DEPTH), 32'd1);
    hold       = bus.InstrValid && !bus.InstrReady && !bus.Redirect;
    hold_pc    = bus.InstrPC;
    hold_instr = bus.Instr;
    if (bus.Redirect) begin
      exp_pc  = bus.RedirectPC & ~32'd3;
      exp_req = exp_pc;
    end
    cyc++;
  endtask

  task automatic rand_cycle();
    logic rv;
    rv = mq_addr.size() > 0 && mq_due[0] <= cyc;
    apply($urandom_range(0, 99) < gnt_pct, rv, $urandom_range(0, 99) < rdy_pct,
          $urandom_range(0, 99) < redir_pct, $urandom);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.ImemGnt = 0; bus.ImemRvalid = 0; bus.InstrReady = 0; bus.Redirect = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    exp_pc  = 32'd0;
    exp_req = 32'd0;
    hold    = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    bus.Redirect = 0; bus.RedirectPC = 0; bus.ImemGnt = 0; bus.ImemRvalid = 0;
    bus.ImemRdata = 0; bus.InstrReady = 0;
    wbus.Redirect = 0; wbus.RedirectPC = 0; wbus.ImemGnt = 0; wbus.ImemRvalid = 0;
    wbus.ImemRdata = 0; wbus.InstrReady = 0;
    hold = 0; exp_pc = 0; exp_req = 0; max_dly = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", 32'(bus.ImemReq), 32'd0);
    chk("reset_valid", 32'(bus.InstrValid), 32'd0);
    chk("reset_instr", bus.Instr, RV_NOP);
    chk("reset_pc", bus.InstrPC, 32'd0);
    chk("reset_addr", bus.ImemAddr, 32'd0);
    chk("reset_addr_wrap", wbus.ImemAddr, 32'hFFFF_FFF8);
    reset = 1'b0;
    wbus.ImemGnt = 1'b1;
    #1;
    chk("wrap_req0", 32'(wbus.ImemReq), 32'd1);
    chk("wrap_addr0", wbus.ImemAddr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_addr1", wbus.ImemAddr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_req2", 32'(wbus.ImemReq), 32'd1);
    chk("wrap_addr2", wbus.ImemAddr, 32'h0000_0000);
    wbus.ImemGnt = 1'b0;

    do_reset();
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; max_dly = 0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      rand_cycle();
      if (i >= 10) vcount += int'(bus.InstrValid);
    end
    chk("throughput", 32'(vcount), 32'd20);
    rdy_pct = 0;
    for (int i = 0; i < 10; i++) rand_cycle();
    chk("stall_req_low", 32'(bus.ImemReq), 32'd0);
    chk("stall_valid", 32'(bus.InstrValid), 32'd1);
    rdy_pct = 100;
    for (int i = 0; i < 20; i++) rand_cycle();

    add(1,0,0,0,0,        1,32'h000,0,32'h000);
    add(1,1,0,0,0,        1,32'h004,0,32'h000);
    add(1,0,0,0,0,        1,32'h008,1,32'h000);
    add(1,1,0,0,0,        1,32'h00C,1,32'h000);
    add(1,0,0,0,0,        0,32'h010,1,32'h000);
    add(1,1,0,0,0,        0,32'h010,1,32'h000);
    add(0,0,1,0,0,        0,32'h010,1,32'h000);
    add(0,0,1,0,0,        1,32'h010,1,32'h004);
    add(1,0,0,0,0,        1,32'h010,1,32'h008);
    add(1,0,1,1,32'h102,  0,32'h014,1,32'h008);
    add(0,1,1,0,0,        1,32'h100,0,32'h000);
    add(1,0,1,0,0,        1,32'h100,0,32'h000);
    add(1,1,1,0,0,        1,32'h104,0,32'h000);
    add(0,1,1,0,0,        1,32'h108,0,32'h000);
    add(0,0,1,0,0,        1,32'h108,1,32'h100);
    add(1,1,0,0,0,        1,32'h108,0,32'h000);
    add(1,0,0,0,0,        1,32'h10C,1,32'h104);
    add(1,1,1,1,32'h200,  0,32'h110,1,32'h104);
    add(0,0,1,0,0,        1,32'h200,0,32'h000);
    add(0,1,1,0,0,        1,32'h200,0,32'h000);
    add(1,0,1,0,0,        1,32'h200,0,32'h000);
    add(0,1,1,0,0,        1,32'h204,0,32'h000);
    add(0,0,1,0,0,        1,32'h204,1,32'h200);
    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].g, tbl[i].rv, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("tbl%0d_req", i), 32'(bus.ImemReq), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), bus.ImemAddr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.InstrValid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i), bus.InstrPC, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), bus.Instr, tbl[i].vld ? mem_word(tbl[i].pc) : RV_NOP);
      commit();
    end

    do_reset();
    gnt_pct = 60; rdy_pct = 70; redir_pct = 3; max_dly = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
